// File: rtl/svc_soc_io_uart_rx.sv
// 8N1 UART receiver with an MMIO-mapped RX byte FIFO, plus sticky overrun and framing flags.
// Only address bits [7:0] are decoded. The bytes are read from RX_DATA (0x10); the status is at RX_STATUS (0x14).
module svc_soc_io_uart_rx #(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        uart_rx,
  output logic        rx_irq
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int NW           = $clog2(FIFO_DEPTH + 1);

  // The counter runs down to zero. Each load is therefore (interval - 1).
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);
  localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_DATA = 8'h10;
  localparam logic [7:0] ADDR_STAT = 8'h14;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic          r_sync1, r_sync2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitidx;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [NW-1:0] r_count;
  logic          r_ovr, r_fe;

  logic w_line, w_tick, w_push, w_fe_set;
  logic w_not_empty, w_full, w_pop, w_push_ok, w_ovr_set, w_clr;
  logic w_unused;

  assign w_unused = ^{io_wstrb, io_waddr[31:8], io_raddr[31:8], io_wdata[31:3], io_wdata[0]};

  // The serial line is asynchronous. It passes through two flops, which idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line   = r_sync2;
  assign w_tick   = (r_cnt == '0);
  assign w_push   = (r_state == ST_STOP) && w_tick && w_line;
  assign w_fe_set = (r_state == ST_STOP) && w_tick && !w_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_line) begin
            r_state <= ST_START;
            r_cnt   <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!w_line) begin
            r_state  <= ST_DATA;
            r_cnt    <= FULL_LOAD;
            r_bitidx <= '0;
          end else begin
            // The line went high before mid-start. Treat it as a glitch and return quietly.
            r_state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= {w_line, r_shift[7:1]};
            r_cnt   <= FULL_LOAD;
            if (r_bitidx == 3'd7) r_state <= ST_STOP;
            else                  r_bitidx <= r_bitidx + 1'b1;
          end
        end
        ST_STOP: begin
          if (!w_tick) r_cnt <= r_cnt - 1'b1;
          else         r_state <= w_line ? ST_IDLE : ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (w_line) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == DEPTH_N);
  assign w_pop       = io_ren && (io_raddr[7:0] == ADDR_DATA) && w_not_empty;
  // On a full FIFO, a same-edge pop frees the slot that the push needs.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_ovr_set   = w_push && w_full && !w_pop;
  assign w_clr       = io_wen && (io_waddr[7:0] == ADDR_STAT);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A write-1-to-clear loses to a set on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovr <= 1'b0;
      r_fe  <= 1'b0;
    end else begin
      r_ovr <= w_ovr_set | (r_ovr & ~(w_clr & io_wdata[1]));
      r_fe  <= w_fe_set  | (r_fe  & ~(w_clr & io_wdata[2]));
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_ren) begin
      case (io_raddr[7:0])
        ADDR_DATA: begin
          io_rdata[31] = w_not_empty;
          if (w_not_empty) io_rdata[7:0] = r_mem[r_rptr];
        end
        ADDR_STAT: begin
          io_rdata[11:8] = 4'(r_count);
          io_rdata[2]    = r_fe;
          io_rdata[1]    = r_ovr;
          io_rdata[0]    = w_not_empty;
        end
        default: io_rdata = '0;
      endcase
    end
  end

  assign rx_irq = w_not_empty;

endmodule

// File: doc/svc_soc_io_uart_rx.md
SVC_SOC_IO_UART_RX -- requirements
Module: svc_soc_io_uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 25_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning RX byte FIFO entries (power of two, at least 2).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 io_wen  input  1  MMIO write strobe, single cycle.
REQ-008 io_waddr  input  32  MMIO write address; only bits [7:0] decoded.
REQ-009 io_wdata  input  32  MMIO write data.
REQ-010 io_wstrb  input  4  byte strobes, ignored.
REQ-011 io_ren  input  1  MMIO read strobe, single cycle.
REQ-012 io_raddr  input  32  MMIO read address; only bits [7:0] decoded.
REQ-013 io_rdata  output  32  MMIO read data, combinational, same cycle as io_ren.
REQ-014 uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-015 rx_irq  output  1  high while FIFO not empty.

Function
REQ-016 Register map (offset = addr[7:0]): 0x10 RX_DATA (read pops); 0x14 RX_STATUS (read; W1C on bits 2:1); all other offsets read 0 and ignore writes.
REQ-017 RX_DATA read: bit31 = FIFO not empty, bits[7:0] = FIFO head byte when not empty, else 0; all other bits 0.
REQ-018 RX_STATUS: bit0 = FIFO not empty, bit1 = overrun (sticky), bit2 = framing error (sticky), bits[11:8] = FIFO occupancy count, others 0.
REQ-019 io_rdata SHALL be 0 whenever io_ren is low.
REQ-020 Pop: on a clock edge with io_ren, raddr[7:0]==0x10 and FIFO not empty, head is removed; read when empty has no side effect.
REQ-021 uart_rx SHALL pass through a 2-flop synchronizer before use; synchronizer flops reset to 1.
REQ-022 CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer divide); sample counter sized for it.
REQ-023 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-024 IDLE: synchronized line low -> START, counter loaded to sample at CLKS_PER_BIT/2.
REQ-025 START: at half-bit, line low -> DATA with counter reloaded to CLKS_PER_BIT; line high -> IDLE (glitch rejected, no flag).
REQ-026 DATA: sample every CLKS_PER_BIT clocks, shift LSB first; after 8th bit -> STOP.
REQ-027 STOP: after CLKS_PER_BIT, line high -> push byte, IDLE; line low -> set framing error, discard byte, WAIT_IDLE.
REQ-028 WAIT_IDLE: remain until synchronized line high, then IDLE.
REQ-029 Push onto full FIFO SHALL drop the byte and set overrun; FIFO contents unchanged.
REQ-030 Push and pop on the same edge when full: both occur, no overrun; when empty: push occurs, pop ignored.
REQ-031 Write to 0x14 with wdata bit1/bit2 = 1 clears overrun/framing flag; a same-cycle set SHALL win over clear.
REQ-032 Pushed byte visible on RX_STATUS bit0 and rx_irq the cycle after the stop-bit sample edge.
REQ-033 FIFO pointers wrap modulo FIFO_DEPTH; occupancy count ranges 0..FIFO_DEPTH.

Reset
REQ-034 Reset SHALL force: FSM IDLE, FIFO empty, count 0, both flags 0, rx_irq 0, synchronizer flops 1, shift and sample counters 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts only on a new falling edge.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, 10 clk/bit)
REQ-036 Send 0xA5 8N1 -> rx_irq rises; read 0x14 = 0x101; read 0x10 = 0x800000A5; next read 0x14 = 0x000.
REQ-037 Send 5 bytes 0x01..0x05 with no reads -> 0x14 = 0x403; reads of 0x10 return 0x01..0x04 then 0x00000000; write 0x14 data 0x2 -> 0x14 = 0x000.
REQ-038 Send 0x3C with stop bit low, line held low 30 clk then high -> 0x14 = 0x004, FIFO empty; then 0x55 received normally -> 0x14 = 0x105.
REQ-039 uart_rx low pulse of 3 clk -> no byte, no flags, FSM back in IDLE.
REQ-040 FIFO full, pop on same edge as stop-bit push -> no overrun, count stays 4, byte order preserved.
REQ-041 rst asserted during DATA bit 4 of a frame -> all outputs 0, next full frame 0x7E received correctly.
